// File: rtl/pll_reset_ctrl_if.sv
// Reset-controller signal bundle: PLL lock and external reset request in,
// core reset/ready/diagnostic counter out.
//   lock          : PLL lock, asynchronous to clk
//   ext_rst_req   : external reset request, asynchronous, active-high
//   sys_rst       : registered active-high core reset
//   sys_rst_n     : registered complement of sys_rst
//   ready         : high only while the controller is in RUN
//   lock_loss_cnt : saturating count of lock drops seen while in RUN
interface pll_reset_ctrl_if;
  logic       lock;
  logic       ext_rst_req;
  logic       sys_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  modport master (
    output lock,
    output ext_rst_req,
    input  sys_rst,
    input  sys_rst_n,
    input  ready,
    input  lock_loss_cnt
  );

  modport slave (
    input  lock,
    input  ext_rst_req,
    output sys_rst,
    output sys_rst_n,
    output ready,
    output lock_loss_cnt
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL-driven reset sequencer. Holds the core in reset until the PLL lock has
// been stable for STABLE_CYCLES, then keeps reset asserted HOLD_CYCLES more
// before entering RUN. Any lock loss or external request restarts the whole
// sequence; lock drops seen in RUN are counted (saturating at 255).
//   clk : sole clock (PLL clkout)
//   rst : asynchronous active-high reset
//   bus : pll_reset_ctrl_if slave (lock, ext_rst_req in; sys_rst, sys_rst_n,
//         ready, lock_loss_cnt out)
module pll_reset_ctrl #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pll_reset_ctrl_if.slave   bus
);

  localparam int unsigned CNT_MAX = ((STABLE_CYCLES > HOLD_CYCLES) ?
                                     STABLE_CYCLES : HOLD_CYCLES) - 1;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    loss, loss_n;
  logic [1:0]    lock_sync, req_sync;
  logic          lock_s, req_s;
  logic          sys_rst_q, sys_rst_n_q, ready_q;

  assign lock_s = lock_sync[1];
  assign req_s  = req_sync[1];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    loss_n  = loss;
    case (state)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lock_s && !req_s) state_n = STABLE;
      end
      STABLE: begin
        if (!lock_s || req_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (!lock_s || req_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s || req_s) state_n = WAIT_LOCK;
        // Only a lock drop counts; a simultaneous request still counts once.
        if (!lock_s && (loss != '1)) loss_n = loss + 8'd1;
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync   <= '0;
      req_sync    <= '0;
      state       <= WAIT_LOCK;
      cnt         <= '0;
      loss        <= '0;
      sys_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      lock_sync   <= {lock_sync[0], bus.lock};
      req_sync    <= {req_sync[0], bus.ext_rst_req};
      state       <= state_n;
      cnt         <= cnt_n;
      loss        <= loss_n;
      // Outputs load from the next state so they switch on the same edge as
      // the state register without a decode path behind them.
      sys_rst_q   <= (state_n != RUN);
      sys_rst_n_q <= (state_n == RUN);
      ready_q     <= (state_n == RUN);
    end
  end

  assign bus.sys_rst       = sys_rst_q;
  assign bus.sys_rst_n     = sys_rst_n_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = loss;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl with STABLE_CYCLES=4, HOLD_CYCLES=2.
// The reference model reduces the controller to one rule: the core is out of
// reset once the synchronised inputs have been "good" (lock high, request low)
// for 1+STABLE+HOLD consecutive clock evaluations; any bad evaluation clears
// the streak, and a low lock while out of reset bumps the loss counter.
module tb_pll_reset_ctrl;
  localparam int unsigned S = 4;
  localparam int unsigned H = 2;
  localparam int unsigned RUN_STREAK = 1 + S + H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_reset_ctrl_if bus ();

  pll_reset_ctrl #(
    .STABLE_CYCLES(S),
    .HOLD_CYCLES  (H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       m_l1 = 1'b0, m_l2 = 1'b0, m_r1 = 1'b0, m_r2 = 1'b0;
  logic       m_ls, m_rs;
  int         m_streak = 0;
  logic [7:0] m_loss = 8'd0;
  logic       m_run = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_l1 = 1'b0; m_l2 = 1'b0; m_r1 = 1'b0; m_r2 = 1'b0;
      m_streak = 0;
      m_loss   = 8'd0;
      m_run    = 1'b0;
    end else begin
      m_ls = m_l2;
      m_rs = m_r2;
      m_l2 = m_l1; m_l1 = bus.lock;
      m_r2 = m_r1; m_r1 = bus.ext_rst_req;
      if (m_run && !m_ls && m_loss != 8'd255) m_loss = m_loss + 8'd1;
      if (m_ls && !m_rs) begin
        if (m_streak < 1000) m_streak++;
      end else begin
        m_streak = 0;
      end
      m_run = (m_streak >= RUN_STREAK);
    end
  end

  always @(negedge clk) begin
    chk("m_sys_rst",   {31'd0, bus.sys_rst},   {31'd0, !m_run});
    chk("m_sys_rst_n", {31'd0, bus.sys_rst_n}, {31'd0, m_run});
    chk("m_ready",     {31'd0, bus.ready},     {31'd0, m_run});
    chk("m_loss_cnt",  {24'd0, bus.lock_loss_cnt}, {24'd0, m_loss});
  end

  // ---------------- directed stimulus ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs made good just before calling: expect reset through 8 edges,
  // release on the 9th (counting the first sampling edge as edge 1).
  task automatic expect_release(input string name);
    for (int i = 1; i <= 8; i++) begin
      edges(1);
      chk({name, "_held"}, {31'd0, bus.sys_rst}, 32'd1);
    end
    edges(1);
    chk({name, "_rst"},   {31'd0, bus.sys_rst},   32'd0);
    chk({name, "_rst_n"}, {31'd0, bus.sys_rst_n}, 32'd1);
    chk({name, "_ready"}, {31'd0, bus.ready},     32'd1);
  endtask

  initial begin
    bus.lock        = 1'b0;
    bus.ext_rst_req = 1'b0;
    rst             = 1'b1;
    edges(2);
    chk("rst_sys_rst",   {31'd0, bus.sys_rst},   32'd1);
    chk("rst_sys_rst_n", {31'd0, bus.sys_rst_n}, 32'd0);
    chk("rst_ready",     {31'd0, bus.ready},     32'd0);
    chk("rst_loss",      {24'd0, bus.lock_loss_cnt}, 32'd0);
    rst = 1'b0;
    edges(2);

    // Lock drops while STABLE counter sits at 2.
    bus.lock = 1'b1;
    edges(3);
    bus.lock = 1'b0;
    edges(4);
    chk("stable_drop_rst",  {31'd0, bus.sys_rst}, 32'd1);
    chk("stable_drop_loss", {24'd0, bus.lock_loss_cnt}, 32'd0);
    bus.lock = 1'b1;
    expect_release("first_run");

    // Lock lost for 3 cycles in RUN.
    bus.lock = 1'b0;
    edges(2);
    chk("loss_edge2_rst", {31'd0, bus.sys_rst}, 32'd0);
    edges(1);
    chk("loss_edge3_rst",   {31'd0, bus.sys_rst}, 32'd1);
    chk("loss_edge3_ready", {31'd0, bus.ready},   32'd0);
    chk("loss_edge3_cnt",   {24'd0, bus.lock_loss_cnt}, 32'd1);
    bus.lock = 1'b1;
    expect_release("relock");

    // External request for 5 cycles in RUN.
    bus.ext_rst_req = 1'b1;
    edges(2);
    chk("req_edge2_rst", {31'd0, bus.sys_rst}, 32'd0);
    edges(1);
    chk("req_edge3_rst", {31'd0, bus.sys_rst}, 32'd1);
    chk("req_loss_same", {24'd0, bus.lock_loss_cnt}, 32'd1);
    edges(2);
    bus.ext_rst_req = 1'b0;
    expect_release("req_release");
    chk("req_loss_after", {24'd0, bus.lock_loss_cnt}, 32'd1);

    // Lock drop and request together count once.
    bus.lock = 1'b0;
    bus.ext_rst_req = 1'b1;
    edges(4);
    chk("both_loss", {24'd0, bus.lock_loss_cnt}, 32'd2);
    bus.lock = 1'b1;
    bus.ext_rst_req = 1'b0;
    expect_release("both_release");

    // 260 drops from RUN: counter saturates.
    for (int k = 0; k < 260; k++) begin
      bus.lock = 1'b0;
      edges(3);
      bus.lock = 1'b1;
      edges(9);
      chk("sweep_loss", {24'd0, bus.lock_loss_cnt}, (k + 3 > 255) ? 32'd255 : 32'(k + 3));
      chk("sweep_run",  {31'd0, bus.ready}, 32'd1);
    end
    chk("sat_loss", {24'd0, bus.lock_loss_cnt}, 32'd255);

    // Asynchronous reset while in HOLD.
    bus.lock = 1'b0;
    edges(3);
    bus.lock = 1'b1;
    edges(7);
    #2;
    rst = 1'b1;
    #1;
    chk("hold_rst_sys_rst",   {31'd0, bus.sys_rst},   32'd1);
    chk("hold_rst_sys_rst_n", {31'd0, bus.sys_rst_n}, 32'd0);
    chk("hold_rst_ready",     {31'd0, bus.ready},     32'd0);
    chk("hold_rst_loss",      {24'd0, bus.lock_loss_cnt}, 32'd0);
    edges(2);
    rst = 1'b0;
    expect_release("after_hold_rst");

    edges(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
